// File: rtl/mem_writeback.sv
// Writeback stage: retires instructions from the memory stage, waits for load data,
// drives the register-file write port and counts retired instructions.
module mem_writeback #(
  parameter int          DATA_W       = 32,
  parameter int          REG_AW       = 5,
  parameter int          LOAD_TIMEOUT = 255,
  parameter logic [31:0] COUNT_RST    = 32'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mem_op,
  input  logic              in_reg_wen,
  input  logic [REG_AW-1:0] in_reg_dest,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              dc_resp_valid,
  input  logic [DATA_W-1:0] dc_resp_data,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              load_timeout_err,
  output logic [31:0]       retired_count
);

  // Handshake: a transfer happens on a rising edge where in_valid & in_ready;
  // in_ready depends only on state, never on in_valid.
  typedef enum logic {S_IDLE = 1'b0, S_WAIT_LD = 1'b1} state_t;

  localparam logic [1:0]  OP_LW      = 2'd1;
  localparam logic [1:0]  OP_SW      = 2'd2;
  localparam logic [15:0] L_TMO_LAST = 16'(LOAD_TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [15:0]         r_timer;
  logic                r_ld_wen;
  logic [REG_AW-1:0]   r_ld_dest;

  logic                w_xfer;
  logic                w_start_ld;
  logic                w_retire;
  logic                w_timeout;
  logic                w_wr_en;
  logic [REG_AW-1:0]   w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid && in_mem_op == OP_LW) w_next_state = S_WAIT_LD;
      end
      S_WAIT_LD: begin
        // A response in the last allowed cycle still wins over the timeout.
        if (dc_resp_valid || r_timer == L_TMO_LAST) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    w_xfer     = 1'b0;
    w_start_ld = 1'b0;
    w_retire   = 1'b0;
    w_timeout  = 1'b0;
    w_wr_en    = 1'b0;
    w_wr_addr  = in_reg_dest;
    w_wr_data  = in_alu_result;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        w_xfer   = in_valid;
        if (w_xfer) begin
          if (in_mem_op == OP_LW) begin
            w_start_ld = 1'b1;
          end else begin
            w_retire = 1'b1;
            w_wr_en  = (in_mem_op != OP_SW) && in_reg_wen && (in_reg_dest != '0);
          end
        end
      end
      S_WAIT_LD: begin
        busy      = 1'b1;
        w_wr_addr = r_ld_dest;
        w_wr_data = dc_resp_data;
        if (dc_resp_valid) begin
          w_retire = 1'b1;
          w_wr_en  = r_ld_wen && (r_ld_dest != '0);
        end else if (r_timer == L_TMO_LAST) begin
          w_timeout = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen           <= 1'b0;
      rf_waddr         <= '0;
      rf_wdata         <= '0;
      load_timeout_err <= 1'b0;
      retired_count    <= COUNT_RST;
      r_timer          <= '0;
      r_ld_wen         <= 1'b0;
      r_ld_dest        <= '0;
    end else begin
      rf_wen <= w_wr_en;
      if (w_wr_en) begin
        rf_waddr <= w_wr_addr;
        rf_wdata <= w_wr_data;
      end
      if (w_retire)  retired_count    <= retired_count + 32'd1;
      if (w_timeout) load_timeout_err <= 1'b1;
      if (w_start_ld) begin
        r_timer   <= '0;
        r_ld_wen  <= in_reg_wen;
        r_ld_dest <= in_reg_dest;
      end else if (busy) begin
        r_timer <= r_timer + 16'd1;
      end
    end
  end

endmodule
